dtc_walker: RTL and testbench

Parametrised, sequential decision-tree classifier. It replaces hard-wired per-model trees with a runtime-loadable node table. One feature vector is accepted per classification. The block walks the table one node per cycle from the root and returns the leaf class through a valid/ready handshake. It sits between the feature-extraction stage and the class consumer, and the table is written from the configuration bus.

---
 rtl/dtc_pkg.sv | 78 +++++++
 rtl/dtc_walker_if.sv | 40 ++++
 rtl/dtc_node_table.sv | 45 ++++
 rtl/dtc_walker.sv | 147 ++++++++++++++
 tb/tb_dtc_walker.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dtc_pkg.sv
// dtc_walker shared types: node-word field layout, FSM states,
// and node_t packing helpers for the default table geometry.
package dtc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    DONE
  } state_e;

  function automatic int cls_lsb();
    return 0;
  endfunction

  function automatic int pz_lsb(input int ow);
    return ow;
  endfunction

  function automatic int po_lsb(input int pw, input int ow);
    return ow + pw;
  endfunction

  function automatic int fidx_lsb(input int pw, input int ow);
    return ow + 2 * pw;
  endfunction

  function automatic int leaf_bit(
    input int fw,
    input int pw,
    input int ow
  );
    return ow + 2 * pw + fw;
  endfunction

  function automatic int node_w(
    input int fw,
    input int pw,
    input int ow
  );
    return leaf_bit(fw, pw, ow) + 1;
  endfunction

  localparam int DEF_FIDX_W = 4;
  localparam int DEF_PTR_W  = 6;
  localparam int DEF_OUT_W  = 3;

  typedef struct packed {
    logic                  is_leaf;
    logic [DEF_FIDX_W-1:0] feat_idx;
    logic [DEF_PTR_W-1:0]  ptr_one;
    logic [DEF_PTR_W-1:0]  ptr_zero;
    logic [DEF_OUT_W-1:0]  cls;
  } node_t;

  function automatic node_t leaf_node(
    input logic [DEF_OUT_W-1:0] c
  );
    node_t n;
    n = '0;
    n.is_leaf = 1'b1;
    n.cls = c;
    return n;
  endfunction

  function automatic node_t int_node(
    input logic [DEF_FIDX_W-1:0] f,
    input logic [DEF_PTR_W-1:0]  p1,
    input logic [DEF_PTR_W-1:0]  p0
  );
    node_t n;
    n = '0;
    n.feat_idx = f;
    n.ptr_one = p1;
    n.ptr_zero = p0;
    return n;
  endfunction

endpackage

// File: rtl/dtc_walker_if.sv
// dtc_walker bus: config write port, feature input and
// class output handshakes.
interface dtc_walker_if
  import dtc_pkg::*;
#(
  parameter int N_FEAT = 12,
  parameter int OUT_W  = 3,
  parameter int DEPTH  = 64,
  parameter int FIDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1
);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NODE_W = node_w(FIDX_W, PTR_W, OUT_W);

  logic              cfg_we;
  logic [PTR_W-1:0]  cfg_addr;
  logic [NODE_W-1:0] cfg_data;
  logic              cfg_busy;
  logic              in_valid;
  logic              in_ready;
  logic [N_FEAT-1:0] inp;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  outp;
  logic              out_err;

  modport master (
    output cfg_we, cfg_addr, cfg_data,
    output in_valid, inp, out_ready,
    input  cfg_busy, in_ready,
    input  out_valid, outp, out_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data,
    input  in_valid, inp, out_ready,
    output cfg_busy, in_ready,
    output out_valid, outp, out_err
  );

endinterface

// File: rtl/dtc_node_table.sv
// Node table: flop array, reset to leaf-0, one write port
// and one asynchronous read port.
module dtc_node_table #(
  parameter int DEPTH  = 64,
  parameter int PTR_W  = 6,
  parameter int NODE_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [NODE_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [NODE_W-1:0] rdata
);
  localparam logic [NODE_W-1:0] RST_WORD =
    {1'b1, {(NODE_W-1){1'b0}}};

  logic [NODE_W-1:0] mem_q [DEPTH];
  logic [NODE_W-1:0] mem_d [DEPTH];
  logic              w_ok;

  assign w_ok =
    {1'b0, waddr} < (PTR_W+1)'(DEPTH);

  always_comb begin
    mem_d = mem_q;
    if (we && w_ok) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_WORD;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dtc_walker.sv
// Sequential decision-tree classifier: walks the node table
// one node per cycle from the root and returns the leaf class.
module dtc_walker
  import dtc_pkg::*;
#(
  parameter int N_FEAT     = 12,
  parameter int OUT_W      = 3,
  parameter int DEPTH      = 64,
  parameter int MAX_LEVELS = 8,
  parameter int FIDX_W     = (N_FEAT > 1) ? $clog2(N_FEAT) : 1
) (
  input logic         clk,
  input logic         rst,
  dtc_walker_if.slave bus
);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NODE_W = node_w(FIDX_W, PTR_W, OUT_W);
  localparam int LVL_W  = $clog2(MAX_LEVELS + 1);
  localparam int FEXT   = 1 << FIDX_W;
  localparam int LEAF_B = leaf_bit(FIDX_W, PTR_W, OUT_W);
  localparam int FIDX_L = fidx_lsb(PTR_W, OUT_W);
  localparam int PO_L   = po_lsb(PTR_W, OUT_W);
  localparam int PZ_L   = pz_lsb(OUT_W);
  localparam int CLS_L  = cls_lsb();

  state_e            state_q, state_d;
  logic [N_FEAT-1:0] inp_q, inp_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [OUT_W-1:0]  outp_q, outp_d;
  logic              err_q, err_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [NODE_W-1:0] node;
  logic              is_leaf;
  logic [FIDX_W-1:0] fidx;
  logic [PTR_W-1:0]  p_one;
  logic [PTR_W-1:0]  p_zero;
  logic [OUT_W-1:0]  cls;
  logic [FEXT-1:0]   inp_ext;
  logic              fbit;
  logic [PTR_W-1:0]  nxt;
  logic              nxt_oob;
  logic              tbl_we;

  assign tbl_we = bus.cfg_we && (state_q == IDLE);

  dtc_node_table #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .NODE_W(NODE_W)
  ) u_table (
    .clk  (clk),
    .rst  (rst),
    .we   (tbl_we),
    .waddr(bus.cfg_addr),
    .wdata(bus.cfg_data),
    .raddr(ptr_q),
    .rdata(node)
  );

  assign is_leaf = node[LEAF_B];
  assign fidx    = node[FIDX_L +: FIDX_W];
  assign p_one   = node[PO_L +: PTR_W];
  assign p_zero  = node[PZ_L +: PTR_W];
  assign cls     = node[CLS_L +: OUT_W];

  // Indices past N_FEAT land in the zero-extension and read 0.
  assign inp_ext = FEXT'(inp_q);
  assign fbit    = inp_ext[fidx];
  assign nxt     = fbit ? p_one : p_zero;
  assign nxt_oob =
    {1'b0, nxt} >= (PTR_W+1)'(DEPTH);

  always_comb begin
    state_d = state_q;
    inp_d   = inp_q;
    ptr_d   = ptr_q;
    lvl_d   = lvl_q;
    outp_d  = outp_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          inp_d   = bus.inp;
          ptr_d   = '0;
          lvl_d   = '0;
          state_d = WALK;
        end
      end
      WALK: begin
        if (is_leaf) begin
          outp_d  = cls;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (lvl_q == LVL_W'(MAX_LEVELS)
                     || nxt_oob) begin
          outp_d  = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          ptr_d = nxt;
          lvl_d = lvl_q + LVL_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      inp_q       <= '0;
      ptr_q       <= '0;
      lvl_q       <= '0;
      outp_q      <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      inp_q       <= inp_d;
      ptr_q       <= ptr_d;
      lvl_q       <= lvl_d;
      outp_q      <= outp_d;
      err_q       <= err_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cfg_busy  = busy_q;
  assign bus.outp      = outp_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_dtc_walker.sv
// Self-checking bench for dtc_walker: vector table over a
// loaded chain plus hand sequences for hold, abort and reset.
module tb_dtc_walker;
  import dtc_pkg::*;

  logic clk;
  logic rst;

  dtc_walker_if #(
    .N_FEAT(12),
    .OUT_W (3),
    .DEPTH (64)
  ) bus ();

  dtc_walker #(
    .N_FEAT    (12),
    .OUT_W     (3),
    .DEPTH     (64),
    .MAX_LEVELS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cls;
    logic       err;
  } exp_t;

  typedef struct {
    logic [11:0] inp;
    logic [2:0]  cls;
    logic        err;
    int          lat;
  } vec_t;

  exp_t sb[$];
  vec_t vt[8];
  int   n_cmp;
  int   n_bad;

  task automatic chk(
    input string nm,
    input int    act,
    input int    exp
  );
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic wr_node(
    input logic [5:0] a,
    input node_t      n
  );
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = a;
    bus.cfg_data = n;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic classify(
    input logic [11:0] v,
    input logic [2:0]  ec,
    input logic        ee,
    input int          el,
    input int          hold,
    input logic        wr,
    input node_t       wd
  );
    exp_t e;
    int   lat;
    @(negedge clk);
    chk("in_ready_idle", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.inp      = v;
    if (wr) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = '0;
      bus.cfg_data = wd;
    end
    sb.push_back('{ec, ee});
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    chk("busy_walk", int'(bus.cfg_busy), 1);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    if (!bus.out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: out_valid %0d after %0d edges expected 1",
               bus.out_valid, lat);
      return;
    end
    chk("latency", lat, el);
    chk("class", int'(bus.outp), int'(e.cls));
    chk("err", int'(bus.out_err), int'(e.err));
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = '0;
        bus.cfg_data = leaf_node(3'd5);
      end
      @(negedge clk);
      bus.cfg_we = 1'b0;
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_class", int'(bus.outp), int'(e.cls));
      chk("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("valid_drop", int'(bus.out_valid), 0);
    chk("in_ready_back", int'(bus.in_ready), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: sim time %0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    // Chain table: bit3=1, bit6=0, bit0=1, bit4=1, bit7=0 -> leaf 7.
    vt[0] = '{12'h019, 3'd7, 1'b0, 6};
    vt[1] = '{12'h099, 3'd0, 1'b0, 6};
    vt[2] = '{12'h000, 3'd0, 1'b0, 2};
    vt[3] = '{12'h008, 3'd0, 1'b0, 4};
    vt[4] = '{12'h048, 3'd0, 1'b0, 3};
    vt[5] = '{12'h009, 3'd0, 1'b0, 5};
    vt[6] = '{12'hFFF, 3'd0, 1'b0, 3};
    vt[7] = '{12'h619, 3'd7, 1'b0, 6};

    rst           = 1'b1;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.inp       = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_outp", int'(bus.outp), 0);
    chk("rst_out_err", int'(bus.out_err), 0);
    chk("rst_busy", int'(bus.cfg_busy), 0);

    classify(12'hFFF, 3'd0, 1'b0, 1, 0, 1'b0, '0);

    wr_node(6'd0, int_node(4'd3, 6'd1, 6'd6));
    wr_node(6'd1, int_node(4'd6, 6'd6, 6'd2));
    wr_node(6'd2, int_node(4'd0, 6'd3, 6'd6));
    wr_node(6'd3, int_node(4'd4, 6'd4, 6'd6));
    wr_node(6'd4, int_node(4'd7, 6'd6, 6'd5));
    wr_node(6'd5, leaf_node(3'd7));
    wr_node(6'd6, leaf_node(3'd0));

    for (int i = 0; i < 8; i++) begin
      classify(vt[i].inp, vt[i].cls, vt[i].err,
               vt[i].lat, 0, 1'b0, '0);
    end

    // Stall in DONE; the write to entry 0 there must be dropped.
    classify(12'h019, 3'd7, 1'b0, 6, 5, 1'b0, '0);
    classify(12'h019, 3'd7, 1'b0, 6, 0, 1'b0, '0);

    // Feature index past N_FEAT reads as 0.
    wr_node(6'd0, int_node(4'd15, 6'd1, 6'd2));
    wr_node(6'd1, leaf_node(3'd2));
    wr_node(6'd2, leaf_node(3'd3));
    classify(12'hFFF, 3'd3, 1'b0, 2, 0, 1'b0, '0);

    wr_node(6'd0, int_node(4'd0, 6'd0, 6'd0));
    classify(12'h0A5, 3'd0, 1'b1, 9, 0, 1'b0, '0);

    classify(12'h000, 3'd5, 1'b0, 1, 0, 1'b1,
             leaf_node(3'd5));

    wr_node(6'd0, int_node(4'd0, 6'd0, 6'd0));
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.inp      = 12'h3C3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (bus.out_valid) seen++;
      end
      chk("rst_walk_no_valid", seen, 0);
    end
    chk("rst_walk_in_ready", int'(bus.in_ready), 1);
    classify(12'h019, 3'd0, 1'b0, 1, 0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
